// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and round-robin helper for the UART TX arbiter
package uart_pkg;

    // Arbiter states: ARB looks for a winner, WAIT holds until the serializer finishes.
    localparam logic [0:0] ARB  = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    localparam int UART_BYTE_W = 8;

    // Widest requester set the helper below can search.
    localparam int RR_MAX_REQ = 8;

    // Returns the first set bit of mask at or after ptr, wrapping modulo n.
    // When mask is empty the pointer is returned; callers qualify with |mask.
    function automatic logic [2:0] rr_next(input logic [2:0] ptr,
                                           input logic [7:0] mask,
                                           input int         n);
        logic [2:0] pick;
        int         j;
        pick = ptr;
        // Walk from the farthest candidate back to ptr so the nearest hit wins.
        for (int k = RR_MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (mask[j[2:0]]) begin
                    pick = j[2:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin priority picker
//
// i_mask  : candidate bit per requester
// i_ptr   : index with highest priority this round
// o_idx   : winning index (meaningless when o_found=0)
// o_found : at least one candidate present
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_mask,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);
    import uart_pkg::*;

    logic [2:0] ptr_ext;
    logic [7:0] mask_ext;
    logic [2:0] pick;

    always_comb begin
        ptr_ext  = 3'(i_ptr);
        mask_ext = 8'(i_mask);
        pick     = rr_next(ptr_ext, mask_ext, NUM_REQ);
        o_idx    = IDX_W'(pick);
        o_found  = |i_mask;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharer of one uart_tx serializer with packet locking
//
// clock, reset  : system clock, asynchronous active-high reset
// i_req_valid   : per-requester byte valid, held until o_req_ready
// i_req_data    : per-requester byte, requester r at [8r+7:8r]
// i_req_last    : byte closes the requester's packet
// o_req_ready   : one-hot, one-cycle accept pulse
// o_tx_avail    : one-cycle data-available pulse to the serializer
// o_tx_byte     : byte presented to the serializer
// i_tx_active   : serializer busy
// i_tx_done     : serializer finished a byte (one-cycle pulse)
// o_grant_id    : last granted requester
// o_locked      : packet lock held by o_grant_id
// o_timeout     : sticky watchdog expiry flag
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int LOCK_ON_PACKET = 1,
    parameter int TIMEOUT_CLKS   = 32768,
    parameter int CNT_W          = 16,
    localparam int IDX_W         = $clog2(NUM_REQ)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [8*NUM_REQ-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]     i_req_last,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic                   o_tx_avail,
    output logic [7:0]             o_tx_byte,
    input  logic                   i_tx_active,
    input  logic                   i_tx_done,
    output logic [IDX_W-1:0]       o_grant_id,
    output logic                   o_locked,
    output logic                   o_timeout
);
    import uart_pkg::*;

    logic [0:0]               state_q, state_d;
    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NUM_REQ-1:0]       ready_q, ready_d;
    logic                     avail_q, avail_d;
    logic [UART_BYTE_W-1:0]   byte_q, byte_d;
    logic [IDX_W-1:0]         gid_q, gid_d;
    logic                     locked_q, locked_d;
    logic                     timeout_q, timeout_d;

    logic [NUM_REQ-1:0]       elig;
    logic [IDX_W-1:0]         win_idx;
    logic                     win_found;
    logic [UART_BYTE_W-1:0]   win_byte;
    logic                     win_last;

    // While locked only the holder of the lock (last grantee) may compete.
    always_comb begin
        elig = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            elig[r] = i_req_valid[r] && (!locked_q || (gid_q == IDX_W'(r)));
        end
    end

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_mask  (elig),
        .i_ptr   (ptr_q),
        .o_idx   (win_idx),
        .o_found (win_found)
    );

    always_comb begin
        win_byte = '0;
        win_last = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (win_idx == IDX_W'(r)) begin
                win_byte = i_req_data[8*r +: 8];
                win_last = i_req_last[r];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ready_d   = '0;
        avail_d   = 1'b0;
        byte_d    = byte_q;
        gid_d     = gid_q;
        locked_d  = locked_q;
        timeout_d = timeout_q;

        if (state_q == ARB) begin
            // i_tx_done is deliberately ignored here: a done arriving in ARB is
            // stale, left over from a byte that was in flight across a reset.
            cnt_d = '0;
            if (!i_tx_active && win_found) begin
                byte_d = win_byte;
                gid_d  = win_idx;
                for (int r = 0; r < NUM_REQ; r++) begin
                    ready_d[r] = (win_idx == IDX_W'(r));
                end
                avail_d  = 1'b1;
                ptr_d    = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                locked_d = (LOCK_ON_PACKET != 0) && !win_last;
                state_d  = WAIT;
            end
        end else begin
            if (i_tx_done) begin
                cnt_d   = '0;
                state_d = ARB;
            end else if (cnt_q == CNT_W'(TIMEOUT_CLKS - 1)) begin
                // Serializer never reported done: drop the lock so one stuck
                // packet cannot starve everyone else.
                timeout_d = 1'b1;
                locked_d  = 1'b0;
                cnt_d     = '0;
                state_d   = ARB;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ARB;
            ptr_q     <= '0;
            cnt_q     <= '0;
            ready_q   <= '0;
            avail_q   <= 1'b0;
            byte_q    <= '0;
            gid_q     <= '0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            avail_q   <= avail_d;
            byte_q    <= byte_d;
            gid_q     <= gid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_req_ready = ready_q;
    assign o_tx_avail  = avail_q;
    assign o_tx_byte   = byte_q;
    assign o_grant_id  = gid_q;
    assign o_locked    = locked_q;
    assign o_timeout   = timeout_q;

endmodule
